// File: rtl/meta_mon_pkg.sv
// ============================================================================
//  Module      : meta_mon_pkg
//  Description : Shared FSM state type, default sizes and saturating-add
//                helper for the metastability event monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package meta_mon_pkg;

    localparam int C_DEF_CNT_W  = 8;
    localparam int C_DEF_THRESH = 16;

    typedef enum logic [1:0] {
        ST_MON   = 2'd0,
        ST_ALARM = 2'd1,
        ST_CLR   = 2'd2
    } state_t;

    // Adds two unsigned values and clamps the result at max.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/meta_event_monitor_sat_cnt.sv
// ============================================================================
//  Module      : meta_sat_cnt
//  Description : One per-bit saturating event counter with its sticky flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module meta_sat_cnt
    import meta_mon_pkg::*;
#(
    parameter int CNT_W = C_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             evt,
    output logic [CNT_W-1:0] cnt,
    output logic             sticky
);

    localparam logic [31:0] c_max = (32'd1 << CNT_W) - 32'd1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (clr) begin
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (evt) begin
            r_cnt    <= CNT_W'(sat_add(32'(r_cnt), 32'd1, c_max));
            r_sticky <= 1'b1;
        end
    end

    assign cnt    = r_cnt;
    assign sticky = r_sticky;

endmodule

`default_nettype wire

// File: rtl/meta_event_monitor.sv
// ============================================================================
//  Module      : meta_event_monitor
//  Description : Counts rising-edge mismatch events per bit, keeps a saturating
//                total with a latched threshold alarm and a 4-phase clear.
//                Optional windowed-rate total via META_MON_WINDOW_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module meta_event_monitor
    import meta_mon_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CNT_W      = C_DEF_CNT_W,
    parameter int THRESH     = C_DEF_THRESH,
    parameter int WIN_CYCLES = 1024
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [WIDTH-1:0]                          flag_in,
    input  logic                                      clr_req,
    output logic                                      clr_ack,
    input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] rd_sel,
    output logic [CNT_W-1:0]                          rd_cnt,
    output logic [WIDTH-1:0]                          sticky,
    output logic [CNT_W-1:0]                          total,
    output logic                                      alarm
);

    localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SUM_W = CNT_W + 3;
    localparam logic [SUM_W-1:0] c_max_sum  = SUM_W'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0]      c_thresh   = 32'(THRESH);
    localparam bit               c_thresh_ok = (64'(THRESH) <= ((64'd1 << CNT_W) - 64'd1));

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_flag_prev;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [WIDTH-1:0] w_evt;
    logic             w_clr;
    logic             w_tc;
    logic [SUM_W-1:0] w_popcnt;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_total_next;
    logic             w_hit;
    logic [CNT_W-1:0] w_rd;
    logic [CNT_W-1:0] w_cnt [WIDTH];

    // Clearing starts on the very edge that samples clr_req, so an event
    // coincident with the request is dropped.
    assign w_clr = (r_state == ST_CLR) || clr_req;
    assign w_evt = flag_in & ~r_flag_prev;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcnt = w_popcnt + SUM_W'(w_evt[i]);
        end
    end

`ifdef META_MON_WINDOW_EN
    localparam int WIN_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    logic [WIN_W-1:0] r_win;

    assign w_tc = (r_win == WIN_W'(WIN_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (w_clr || w_tc) begin
            r_win <= '0;
        end else begin
            r_win <= r_win + 1'b1;
        end
    end
`else
    assign w_tc = 1'b0;
`endif

    assign w_sum        = w_tc ? w_popcnt : (SUM_W'(r_total) + w_popcnt);
    assign w_total_next = (w_sum > c_max_sum) ? c_max_sum[CNT_W-1:0] : w_sum[CNT_W-1:0];
    assign w_hit        = c_thresh_ok && (32'(w_total_next) >= c_thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_MON;
            r_flag_prev <= '0;
            r_total     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_clr) begin
                r_flag_prev <= '0;
                r_total     <= '0;
            end else begin
                r_flag_prev <= flag_in;
                r_total     <= w_total_next;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        alarm        = 1'b0;
        clr_ack      = 1'b0;
        case (r_state)
            ST_MON: begin
                if (clr_req) begin
                    w_state_next = ST_CLR;
                end else if (w_hit) begin
                    w_state_next = ST_ALARM;
                end
            end
            ST_ALARM: begin
                alarm = 1'b1;
                if (clr_req) begin
                    w_state_next = ST_CLR;
                end
            end
            ST_CLR: begin
                clr_ack = 1'b1;
                if (!clr_req) begin
                    w_state_next = ST_MON;
                end
            end
            default: begin
                w_state_next = ST_MON;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        meta_sat_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (w_clr),
            .evt    (w_evt[i]),
            .cnt    (w_cnt[i]),
            .sticky (sticky[i])
        );
    end

    // Out-of-range selects match no lane and fall through to zero.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                w_rd = w_cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
        end else begin
            r_rd_cnt <= w_rd;
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign total  = r_total;

endmodule

`default_nettype wire

// File: tb/tb_meta_event_monitor.sv
// ============================================================================
//  Module      : tb_meta_event_monitor
//  Description : Directed self-checking bench for meta_event_monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_meta_event_monitor;

    logic       clk;
    logic       rst_n;
    logic [3:0] flag_in;
    logic       clr_req;
    logic       clr_ack;
    logic [1:0] rd_sel;
    logic [7:0] rd_cnt;
    logic [3:0] sticky;
    logic [7:0] total;
    logic       alarm;

    int checks;
    int failures;

    meta_event_monitor #(
        .WIDTH      (4),
        .CNT_W      (8),
        .THRESH     (16),
        .WIN_CYCLES (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flag_in (flag_in),
        .clr_req (clr_req),
        .clr_ack (clr_ack),
        .rd_sel  (rd_sel),
        .rd_cnt  (rd_cnt),
        .sticky  (sticky),
        .total   (total),
        .alarm   (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        flag_in = v;
        step();
        flag_in = 4'b0000;
        step();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        flag_in  = 4'b0000;
        clr_req  = 1'b0;
        rd_sel   = 2'd0;

        step();
        step();
        chk("rst_total",   32'(total),   32'd0);
        chk("rst_sticky",  32'(sticky),  32'd0);
        chk("rst_alarm",   32'(alarm),   32'd0);
        chk("rst_clr_ack", 32'(clr_ack), 32'd0);
        chk("rst_rd_cnt",  32'(rd_cnt),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef META_MON_WINDOW_EN
        // Held flag counts once per bit
        flag_in = 4'b1111;
        for (int i = 0; i < 10; i++) step();
        flag_in = 4'b0000;
        step();
        chk("held_total",  32'(total),  32'd4);
        chk("held_sticky", 32'(sticky), 32'hF);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            step();
            chk($sformatf("held_cnt%0d", i), 32'(rd_cnt), 32'd1);
        end

        // Single pulses on bit 0
        for (int i = 0; i < 3; i++) pulse(4'b0001);
        rd_sel = 2'd0;
        step();
        chk("pulse_cnt0",  32'(rd_cnt), 32'd4);
        chk("pulse_total", 32'(total),  32'd7);
        chk("pulse_alarm", 32'(alarm),  32'd0);

        // Threshold boundary: 15 no alarm, 16 alarm on the same edge
        for (int i = 0; i < 8; i++) pulse(4'b0010);
        chk("thr_total15", 32'(total), 32'd15);
        chk("thr_alarm15", 32'(alarm), 32'd0);
        flag_in = 4'b0010;
        step();
        chk("thr_total16", 32'(total), 32'd16);
        chk("thr_alarm16", 32'(alarm), 32'd1);
        flag_in = 4'b0000;
        step();

        // Total saturation without wrap
        for (int i = 0; i < 59; i++) pulse(4'b1111);
        chk("sat_total252", 32'(total), 32'd252);
        pulse(4'b1111);
        chk("sat_total255", 32'(total), 32'd255);
        for (int i = 0; i < 10; i++) pulse(4'b1111);
        chk("sat_total_hold", 32'(total), 32'd255);
        rd_sel = 2'd1;
        step();
        chk("cnt1_80", 32'(rd_cnt), 32'd80);
        for (int i = 0; i < 200; i++) pulse(4'b1111);
        rd_sel = 2'd2;
        step();
        chk("cnt2_sat",  32'(rd_cnt), 32'd255);
        chk("alarm_sat", 32'(alarm),  32'd1);

        // Clear handshake with coincident and in-clear events dropped
        clr_req = 1'b1;
        flag_in = 4'b0001;
        step();
        chk("clr_ack_hi",  32'(clr_ack), 32'd1);
        chk("clr_total",   32'(total),   32'd0);
        chk("clr_sticky",  32'(sticky),  32'd0);
        chk("clr_alarm",   32'(alarm),   32'd0);
        flag_in = 4'b0000;
        step();
        flag_in = 4'b0001;
        step();
        flag_in = 4'b0000;
        step();
        chk("clr_rd_cnt",     32'(rd_cnt),  32'd0);
        chk("clr_hold_total", 32'(total),   32'd0);
        chk("clr_hold_stk",   32'(sticky),  32'd0);
        chk("clr_hold_ack",   32'(clr_ack), 32'd1);
        flag_in = 4'b0001;
        clr_req = 1'b0;
        step();
        chk("clr_ack_lo",     32'(clr_ack), 32'd0);
        chk("clr_exit_total", 32'(total),   32'd0);
        step();
        chk("exit_evt_total",  32'(total),  32'd1);
        chk("exit_evt_sticky", 32'(sticky), 32'd1);
        flag_in = 4'b0000;
        step();

        // Asynchronous reset while in ALARM
        for (int i = 0; i < 4; i++) pulse(4'b1111);
        chk("re_alarm", 32'(alarm), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_alarm",  32'(alarm),  32'd0);
        chk("arst_total",  32'(total),  32'd0);
        chk("arst_sticky", 32'(sticky), 32'd0);
        chk("arst_rd_cnt", 32'(rd_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while in CLR
        clr_req = 1'b1;
        step();
        chk("mclr_ack", 32'(clr_ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_clr_ack", 32'(clr_ack), 32'd0);
        clr_req = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        flag_in = 4'b0010;
        step();
        step();
        step();
        chk("post_rst_total",  32'(total),  32'd1);
        chk("post_rst_sticky", 32'(sticky), 32'd2);
        rd_sel = 2'd1;
        step();
        chk("post_rst_cnt1", 32'(rd_cnt), 32'd1);
        flag_in = 4'b0000;
`else
        // Windowed total: window spans edges 1..8 after reset release
        apply_reset();
        pulse(4'b0001);
        pulse(4'b0001);
        pulse(4'b0001);
        chk("win1_total", 32'(total), 32'd3);
        step();
        step();
        chk("win_tc_total", 32'(total), 32'd0);
        flag_in = 4'b0001;
        step();
        chk("win2_total", 32'(total), 32'd1);
        flag_in = 4'b0000;
        rd_sel  = 2'd0;
        step();
        chk("win_cnt0",    32'(rd_cnt), 32'd4);
        chk("win_sticky",  32'(sticky), 32'd1);
        chk("win_alarm",   32'(alarm),  32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
